// File: rtl/fifo_sync_flex_if.sv
// Handshake bundle between a producer/consumer pair and fifo_sync_flex.
// The master modport is the side that pushes, pops and flushes; the FIFO is the slave.
interface fifo_sync_flex_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             flush;
    logic [WIDTH-1:0] wdata;
    logic             wr_en;
    logic             full;
    logic             almost_full;
    logic             rd_en;
    logic [WIDTH-1:0] rdata;
    logic             rvalid;
    logic             empty;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output flush, wdata, wr_en, rd_en,
        input  full, almost_full, rdata, rvalid, empty, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  flush, wdata, wr_en, rd_en,
        output full, almost_full, rdata, rvalid, empty, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/fifo_sync_flex.sv
// Single-clock FIFO with counter-based occupancy (any DEPTH >= 2), programmable
// almost-full/empty thresholds, FWFT or registered read, flush and sticky error flags.
module fifo_sync_flex #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 8,
    parameter int FWFT      = 0,
    parameter int AFULL_TH  = DEPTH - 1,
    parameter int AEMPTY_TH = 1
) (
    input  logic              clk,
    input  logic              rst,
    fifo_sync_flex_if.slave   bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    if (WIDTH < 1) begin : g_bad_width
        $error("fifo_sync_flex: WIDTH must be >= 1");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("fifo_sync_flex: DEPTH must be >= 2");
    end
    if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
        $error("fifo_sync_flex: FWFT must be 0 or 1");
    end
    if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
        $error("fifo_sync_flex: AFULL_TH must be in 1..DEPTH");
    end
    if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty
        $error("fifo_sync_flex: AEMPTY_TH must be in 0..DEPTH-1");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;
    logic             full;
    logic             empty;
    logic             wr_acc;
    logic             rd_acc;

    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    assign wr_acc = bus.wr_en & ~full;
    assign rd_acc = bus.rd_en & ~empty;

    // Memory has no reset; its contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (wr_acc && !bus.flush) begin
            mem[wptr] <= bus.wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (bus.flush) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
            end
            if (rd_acc) begin
                rptr <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (bus.wr_en && full) begin
                overflow <= 1'b1;
            end
            if (bus.rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign bus.rdata  = mem[rptr];
        assign bus.rvalid = ~empty;
    end else begin : g_reg_read
        logic [WIDTH-1:0] rdata_q;
        logic             rvalid_q;

        // rdata keeps its last value across flush so the consumer can still see it.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                rdata_q  <= '0;
                rvalid_q <= 1'b0;
            end else if (bus.flush) begin
                rvalid_q <= 1'b0;
            end else begin
                rvalid_q <= rd_acc;
                if (rd_acc) begin
                    rdata_q <= mem[rptr];
                end
            end
        end

        assign bus.rdata  = rdata_q;
        assign bus.rvalid = rvalid_q;
    end

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count >= CW'(AFULL_TH));
    assign bus.almost_empty = (count <= CW'(AEMPTY_TH));
    assign bus.count        = count;
    assign bus.overflow     = overflow;
    assign bus.underflow    = underflow;
endmodule

// File: tb/tb_fifo_sync_flex.sv
// Self-checking bench: three FIFO instances (DEPTH 8 registered, DEPTH 6 registered,
// DEPTH 8 FWFT) driven by per-scenario tasks against a scoreboard queue.
module tb_fifo_sync_flex;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    logic [7:0] sb[$];
    logic [7:0] exp_d;

    fifo_sync_flex_if #(.WIDTH(8), .DEPTH(8)) ia ();
    fifo_sync_flex_if #(.WIDTH(8), .DEPTH(6)) ib ();
    fifo_sync_flex_if #(.WIDTH(8), .DEPTH(8)) ic ();

    fifo_sync_flex #(.WIDTH(8), .DEPTH(8), .FWFT(0)) dut_a (.clk(clk), .rst(rst), .bus(ia));
    fifo_sync_flex #(.WIDTH(8), .DEPTH(6), .FWFT(0)) dut_b (.clk(clk), .rst(rst), .bus(ib));
    fifo_sync_flex #(.WIDTH(8), .DEPTH(8), .FWFT(1)) dut_c (.clk(clk), .rst(rst), .bus(ic));

    always #5 clk = ~clk;

    // Inputs change at the falling edge; outputs are sampled at the next falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_all();
        ia.flush = 0; ia.wr_en = 0; ia.rd_en = 0; ia.wdata = 0;
        ib.flush = 0; ib.wr_en = 0; ib.rd_en = 0; ib.wdata = 0;
        ic.flush = 0; ic.wr_en = 0; ic.rd_en = 0; ic.wdata = 0;
    endtask

    task automatic test_reset();
        rst = 0;
        idle_all();
        #23;
        n_cmp++;
        if ({ia.empty, ia.almost_empty, ia.full, ia.almost_full, ia.rvalid, ia.overflow, ia.underflow} !== 7'b1100000) begin
            n_bad++;
            $display("FAIL reset_flags got %b want 1100000", {ia.empty, ia.almost_empty, ia.full, ia.almost_full, ia.rvalid, ia.overflow, ia.underflow});
        end
        n_cmp++;
        if (ia.count !== 4'd0 || ia.rdata !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_count_rdata got count=%0d rdata=%h want 0/00", ia.count, ia.rdata);
        end
        @(negedge clk);
        rst = 1;
        tick();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            ia.wr_en = 1;
            ia.wdata = 8'((i + 1) * 17);
            sb.push_back(ia.wdata);
            tick();
            n_cmp++;
            if (ia.count !== 4'(i + 1) || ia.almost_full !== (i + 1 >= 7) || ia.full !== (i + 1 == 8)) begin
                n_bad++;
                $display("FAIL fill_%0d got count=%0d af=%b f=%b want %0d/%b/%b", i, ia.count, ia.almost_full, ia.full, i + 1, (i + 1 >= 7), (i + 1 == 8));
            end
        end
        ia.wdata = 8'h99;
        tick();
        ia.wr_en = 0;
        n_cmp++;
        if (ia.count !== 4'd8 || ia.overflow !== 1'b1) begin
            n_bad++;
            $display("FAIL fill_overflow got count=%0d ovf=%b want 8/1", ia.count, ia.overflow);
        end
    endtask

    task automatic test_drain();
        ia.rd_en = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            exp_d = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
            n_cmp++;
            if (ia.rvalid !== 1'b1 || ia.rdata !== exp_d || ia.count !== 4'(7 - i)) begin
                n_bad++;
                $display("FAIL drain_%0d got rv=%b rdata=%h count=%0d want 1/%h/%0d", i, ia.rvalid, ia.rdata, ia.count, exp_d, 7 - i);
            end
        end
        n_cmp++;
        if (ia.empty !== 1'b1 || ia.underflow !== 1'b0) begin
            n_bad++;
            $display("FAIL drain_empty got empty=%b unf=%b want 1/0", ia.empty, ia.underflow);
        end
        tick();
        ia.rd_en = 0;
        n_cmp++;
        if (ia.underflow !== 1'b1 || ia.rvalid !== 1'b0 || ia.rdata !== 8'h88 || ia.overflow !== 1'b1) begin
            n_bad++;
            $display("FAIL drain_underflow got unf=%b rv=%b rdata=%h ovf=%b want 1/0/88/1", ia.underflow, ia.rvalid, ia.rdata, ia.overflow);
        end
    endtask

    task automatic test_simultaneous();
        ia.flush = 1;
        tick();
        ia.flush = 0;
        n_cmp++;
        if (ia.overflow !== 1'b0 || ia.underflow !== 1'b0 || ia.count !== 4'd0 || ia.rdata !== 8'h88) begin
            n_bad++;
            $display("FAIL flush_clear got ovf=%b unf=%b count=%0d rdata=%h want 0/0/0/88", ia.overflow, ia.underflow, ia.count, ia.rdata);
        end
        for (int i = 0; i < 8; i++) begin
            ia.wr_en = 1;
            ia.wdata = 8'(8'h20 + i);
            sb.push_back(ia.wdata);
            tick();
        end
        ia.rd_en = 1;
        ia.wdata = 8'hEE;
        tick();
        ia.wr_en = 0;
        exp_d = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        n_cmp++;
        if (ia.count !== 4'd7 || ia.overflow !== 1'b1 || ia.rvalid !== 1'b1 || ia.rdata !== exp_d) begin
            n_bad++;
            $display("FAIL simul_full got count=%0d ovf=%b rv=%b rdata=%h want 7/1/1/%h", ia.count, ia.overflow, ia.rvalid, ia.rdata, exp_d);
        end
        for (int i = 0; i < 7; i++) begin
            tick();
            exp_d = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
            n_cmp++;
            if (ia.rdata !== exp_d || ia.rvalid !== 1'b1) begin
                n_bad++;
                $display("FAIL simul_drain_%0d got rdata=%h rv=%b want %h/1", i, ia.rdata, ia.rvalid, exp_d);
            end
        end
        ia.wr_en = 1;
        ia.wdata = 8'h5A;
        sb.push_back(8'h5A);
        tick();
        ia.wr_en = 0;
        n_cmp++;
        if (ia.count !== 4'd1 || ia.underflow !== 1'b1 || ia.rvalid !== 1'b0 || ia.empty !== 1'b0) begin
            n_bad++;
            $display("FAIL simul_empty got count=%0d unf=%b rv=%b empty=%b want 1/1/0/0", ia.count, ia.underflow, ia.rvalid, ia.empty);
        end
        tick();
        ia.rd_en = 0;
        exp_d = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        n_cmp++;
        if (ia.rdata !== exp_d || ia.rvalid !== 1'b1 || ia.count !== 4'd0) begin
            n_bad++;
            $display("FAIL simul_empty_pop got rdata=%h rv=%b count=%0d want %h/1/0", ia.rdata, ia.rvalid, ia.count, exp_d);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 9; i++) begin
            ia.wr_en = 1;
            ia.wdata = 8'(8'h60 + i);
            if (i < 8) sb.push_back(ia.wdata);
            tick();
        end
        ia.wr_en = 0;
        ia.rd_en = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_d = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
            n_cmp++;
            if (ia.rdata !== exp_d) begin
                n_bad++;
                $display("FAIL flush_pre_read_%0d got %h want %h", i, ia.rdata, exp_d);
            end
        end
        ia.rd_en = 0;
        n_cmp++;
        if (ia.count !== 4'd5 || ia.overflow !== 1'b1) begin
            n_bad++;
            $display("FAIL flush_setup got count=%0d ovf=%b want 5/1", ia.count, ia.overflow);
        end
        ia.flush = 1;
        ia.wr_en = 1;
        ia.wdata = 8'hC3;
        tick();
        ia.flush = 0;
        ia.wr_en = 0;
        sb.delete();
        n_cmp++;
        if (ia.count !== 4'd0 || ia.empty !== 1'b1 || ia.overflow !== 1'b0 || ia.rvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_with_write got count=%0d empty=%b ovf=%b rv=%b want 0/1/0/0", ia.count, ia.empty, ia.overflow, ia.rvalid);
        end
        tick();
        n_cmp++;
        if (ia.count !== 4'd0 || ia.empty !== 1'b1) begin
            n_bad++;
            $display("FAIL flush_write_dropped got count=%0d empty=%b want 0/1", ia.count, ia.empty);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            ib.wr_en = 1;
            ib.wdata = 8'(8'h30 + i);
            sb.push_back(ib.wdata);
            tick();
        end
        ib.rd_en = 1;
        for (int k = 0; k < 20; k++) begin
            ib.wdata = 8'(8'h40 + k);
            sb.push_back(ib.wdata);
            tick();
            exp_d = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
            n_cmp++;
            if (ib.count !== 3'd4 || ib.rvalid !== 1'b1 || ib.rdata !== exp_d) begin
                n_bad++;
                $display("FAIL b2b_%0d got count=%0d rv=%b rdata=%h want 4/1/%h", k, ib.count, ib.rvalid, ib.rdata, exp_d);
            end
        end
        ib.wr_en = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_d = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
            n_cmp++;
            if (ib.rdata !== exp_d) begin
                n_bad++;
                $display("FAIL b2b_drain_%0d got %h want %h", i, ib.rdata, exp_d);
            end
        end
        ib.rd_en = 0;
        n_cmp++;
        if (ib.empty !== 1'b1 || ib.underflow !== 1'b0 || ib.overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_end got empty=%b unf=%b ovf=%b want 1/0/0", ib.empty, ib.underflow, ib.overflow);
        end
    endtask

    task automatic test_fwft();
        n_cmp++;
        if (ic.rvalid !== 1'b0 || ic.empty !== 1'b1) begin
            n_bad++;
            $display("FAIL fwft_idle got rv=%b empty=%b want 0/1", ic.rvalid, ic.empty);
        end
        ic.wr_en = 1;
        ic.wdata = 8'hA5;
        sb.push_back(8'hA5);
        tick();
        ic.wr_en = 0;
        n_cmp++;
        if (ic.rvalid !== 1'b1 || ic.rdata !== sb[0]) begin
            n_bad++;
            $display("FAIL fwft_show got rv=%b rdata=%h want 1/%h", ic.rvalid, ic.rdata, sb[0]);
        end
        ic.wr_en = 1;
        ic.wdata = 8'hB6;
        sb.push_back(8'hB6);
        tick();
        ic.wr_en = 0;
        ic.rd_en = 1;
        exp_d = sb.pop_front();
        n_cmp++;
        if (ic.rdata !== exp_d) begin
            n_bad++;
            $display("FAIL fwft_head_stable got %h want %h", ic.rdata, exp_d);
        end
        tick();
        n_cmp++;
        if (ic.rvalid !== 1'b1 || ic.rdata !== sb[0]) begin
            n_bad++;
            $display("FAIL fwft_next got rv=%b rdata=%h want 1/%h", ic.rvalid, ic.rdata, sb[0]);
        end
        tick();
        ic.rd_en = 0;
        void'(sb.pop_front());
        n_cmp++;
        if (ic.empty !== 1'b1 || ic.rvalid !== 1'b0 || ic.underflow !== 1'b0) begin
            n_bad++;
            $display("FAIL fwft_drained got empty=%b rv=%b unf=%b want 1/0/0", ic.empty, ic.rvalid, ic.underflow);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            ia.wr_en = 1;
            ia.wdata = 8'(8'h70 + i);
            tick();
        end
        ia.rd_en = 1;
        ia.wr_en = 1;
        ia.wdata = 8'h73;
        tick();
        n_cmp++;
        if (ia.rvalid !== 1'b1 || ia.rdata !== 8'h70 || ia.count !== 4'd3) begin
            n_bad++;
            $display("FAIL areset_setup got rv=%b rdata=%h count=%0d want 1/70/3", ia.rvalid, ia.rdata, ia.count);
        end
        ia.rd_en = 0;
        ia.wdata = 8'h74;
        #2;
        rst = 0;
        #1;
        n_cmp++;
        if ({ia.empty, ia.almost_empty, ia.full, ia.almost_full, ia.rvalid, ia.overflow, ia.underflow} !== 7'b1100000
            || ia.count !== 4'd0 || ia.rdata !== 8'h00) begin
            n_bad++;
            $display("FAIL areset_async got flags=%b count=%0d rdata=%h want 1100000/0/00",
                     {ia.empty, ia.almost_empty, ia.full, ia.almost_full, ia.rvalid, ia.overflow, ia.underflow}, ia.count, ia.rdata);
        end
        ia.wr_en = 0;
        @(negedge clk);
        rst = 1;
        tick();
        n_cmp++;
        if (ia.count !== 4'd0 || ia.empty !== 1'b1) begin
            n_bad++;
            $display("FAIL areset_release got count=%0d empty=%b want 0/1", ia.count, ia.empty);
        end
        sb.delete();
    endtask

    initial begin
        clk   = 0;
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_fill();
        test_drain();
        test_simultaneous();
        test_flush();
        test_back_to_back();
        test_fwft();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
